core_c1_biu_ifetch: RTL and testbench



---
 rtl/core_c1_pkg.sv | 21 ++
 rtl/core_c1_biu_ifetch.sv | 167 ++++++++++++++++
 tb/tb_core_c1_biu_ifetch.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_c1_pkg.sv
// Shared definitions for the core_c1 bus interface blocks.
package core_c1_pkg;

  // Instruction word returned while no fetch data is available (addi x0,x0,0).
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Bus response status encoding, qualified by rvalid.
  localparam logic BUS_RESP_OK  = 1'b0;
  localparam logic BUS_RESP_ERR = 1'b1;

  typedef enum logic {
    IFETCH_IDLE = 1'b0,
    IFETCH_HOLD = 1'b1
  } ifetch_state_e;

  // Counter width able to hold 0..max_outst inclusive.
  function automatic int outst_cnt_w(input int max_outst);
    return $clog2(max_outst + 1);
  endfunction

endpackage

// File: rtl/core_c1_biu_ifetch.sv
// Instruction-fetch responder: turns IFU PC requests into bus word reads and
// returns in-order instructions, discarding responses killed by a flush.
//
//   state        | meaning
//   -------------+-------------------------------------------------------
//   IFETCH_IDLE  | no held request; a new PC may be issued to the bus
//   IFETCH_HOLD  | request presented but not granted; address in hold_addr_q
module core_c1_biu_ifetch
  import core_c1_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [31:0] RST_INST  = NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_pc_valid,
  input  logic [31:0] i_pc_addr,
  input  logic        i_flush,
  output logic        o_fetch_stall,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic        o_inst_err,
  output logic        o_bus_req,
  output logic [31:0] o_bus_addr,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_err
);

  localparam int unsigned CW = outst_cnt_w(MAX_OUTST);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);
  localparam logic [CW-1:0] ONE     = CW'(1);

  ifetch_state_e state_q, state_d;
  logic [31:0]   hold_addr_q, hold_addr_d;
  logic          hold_kill_q, hold_kill_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          inst_valid_q, inst_valid_d;
  logic [31:0]   inst_q, inst_d;
  logic          inst_err_q, inst_err_d;

  logic          bus_req, fetch_stall, mis_accept;
  logic [31:0]   bus_addr;
  logic          room, misaligned, gnt_acc, rsp_acc;

  assign room       = outst_q < MAX_CNT;
  assign misaligned = i_pc_addr[1:0] != 2'b00;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_acc    = i_bus_rvalid && (outst_q != '0);
  assign gnt_acc    = bus_req && i_bus_gnt;

  // Next state, bus address phase and stall. A held request keeps req/addr
  // stable until granted, even across a flush; the killed read is then dropped.
  always_comb begin
    state_d     = state_q;
    hold_addr_d = hold_addr_q;
    hold_kill_d = 1'b0;
    bus_req     = 1'b0;
    bus_addr    = {i_pc_addr[31:2], 2'b00};
    fetch_stall = 1'b0;
    mis_accept  = 1'b0;
    case (state_q)
      IFETCH_IDLE: begin
        if (i_pc_valid && !i_flush) begin
          if (misaligned) begin
            // Error is reported in order, so wait for all reads to drain.
            fetch_stall = outst_q != '0;
            mis_accept  = outst_q == '0;
          end else if (room) begin
            bus_req = 1'b1;
            if (!i_bus_gnt) begin
              fetch_stall = 1'b1;
              state_d     = IFETCH_HOLD;
              hold_addr_d = bus_addr;
            end
          end else begin
            fetch_stall = 1'b1;
          end
        end
      end
      IFETCH_HOLD: begin
        bus_req     = 1'b1;
        bus_addr    = hold_addr_q;
        // Grant of a killed hold does not accept the IFU's new PC.
        fetch_stall = !i_bus_gnt || hold_kill_q;
        if (i_bus_gnt) begin
          state_d = IFETCH_IDLE;
        end else begin
          hold_kill_d = hold_kill_q || i_flush;
        end
      end
      default: state_d = IFETCH_IDLE;
    endcase
  end

  // Outstanding/drop counters and the registered instruction return.
  always_comb begin
    outst_d = outst_q;
    if (gnt_acc && !rsp_acc) begin
      outst_d = outst_q + ONE;
    end else if (!gnt_acc && rsp_acc) begin
      outst_d = outst_q - ONE;
    end

    drop_d = drop_q;
    if (i_flush) begin
      // Everything still on the bus after this edge belongs to killed fetches.
      drop_d = outst_d;
    end else begin
      if (rsp_acc && (drop_q != '0)) drop_d = drop_d - ONE;
      if (gnt_acc && (state_q == IFETCH_HOLD) && hold_kill_q) drop_d = drop_d + ONE;
    end

    inst_valid_d = 1'b0;
    inst_d       = inst_q;
    inst_err_d   = inst_err_q;
    if (!i_flush) begin
      if (rsp_acc && (drop_q == '0)) begin
        inst_valid_d = 1'b1;
        inst_d       = i_bus_rdata;
        inst_err_d   = (i_bus_err == BUS_RESP_ERR);
      end else if (mis_accept) begin
        inst_valid_d = 1'b1;
        inst_d       = RST_INST;
        inst_err_d   = BUS_RESP_ERR;
      end
    end
  end

  // State and datapath registers, cleared together with the bus side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IFETCH_IDLE;
      hold_addr_q  <= '0;
      hold_kill_q  <= 1'b0;
      outst_q      <= '0;
      drop_q       <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= RST_INST;
      inst_err_q   <= BUS_RESP_OK;
    end else begin
      state_q      <= state_d;
      hold_addr_q  <= hold_addr_d;
      hold_kill_q  <= hold_kill_d;
      outst_q      <= outst_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_err_q   <= inst_err_d;
    end
  end

  // Combinational handshake outputs are held quiet while reset is asserted.
  assign o_bus_req     = bus_req && !rst;
  assign o_fetch_stall = fetch_stall && !rst;
  assign o_bus_addr    = bus_addr;
  assign o_inst_valid  = inst_valid_q;
  assign o_inst        = inst_q;
  assign o_inst_err    = inst_err_q;

  // Bus responses only for issued reads; counters stay within bounds.
  assert property (@(posedge clk) disable iff (rst) i_bus_rvalid |-> (outst_q != '0));
  assert property (@(posedge clk) disable iff (rst) (outst_q <= MAX_CNT) && (drop_q <= outst_q));

endmodule

// File: tb/tb_core_c1_biu_ifetch.sv
// Bench for core_c1_biu_ifetch: the bench acts as IFU and bus slave, and
// predicts outputs from a queue of in-flight reads tagged live or killed.
module tb_core_c1_biu_ifetch;

  localparam int          MAX = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_pc_valid = 1'b0;
  logic [31:0] i_pc_addr = '0;
  logic        i_flush = 1'b0;
  logic        o_fetch_stall, o_inst_valid, o_inst_err, o_bus_req;
  logic [31:0] o_inst, o_bus_addr;
  logic        i_bus_gnt = 1'b0;
  logic        i_bus_rvalid = 1'b0;
  logic [31:0] i_bus_rdata = '0;
  logic        i_bus_err = 1'b0;

  core_c1_biu_ifetch #(.MAX_OUTST(MAX), .RST_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .i_pc_valid(i_pc_valid), .i_pc_addr(i_pc_addr), .i_flush(i_flush),
    .o_fetch_stall(o_fetch_stall), .o_inst_valid(o_inst_valid),
    .o_inst(o_inst), .o_inst_err(o_inst_err),
    .o_bus_req(o_bus_req), .o_bus_addr(o_bus_addr), .i_bus_gnt(i_bus_gnt),
    .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata), .i_bus_err(i_bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    bit          killed;
  } ent_t;

  ent_t        q[$];           // reads on the bus, oldest first
  bit          m_hold, m_hold_kill;
  logic [31:0] m_hold_addr;
  logic        exp_iv, exp_err;
  logic [31:0] exp_inst;
  bit          last_es;
  logic        obs_req, obs_stall, obs_iv, obs_err;
  logic [31:0] obs_addr, obs_inst;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_hold      = 0;
    m_hold_kill = 0;
    m_hold_addr = '0;
    exp_iv      = 1'b0;
    exp_inst    = NOP;
    exp_err     = 1'b0;
    last_es     = 0;
  endtask

  // One clock of stimulus; checks DUT against the model and advances it.
  task automatic cycle(input bit pv, input logic [31:0] pa, input bit fl,
                       input bit g, input bit rv, input bit be);
    bit          er, es, mis_acc, rvalid;
    logic [31:0] ea, rd;
    ent_t        e;
    @(negedge clk);
    rvalid = rv && (q.size() > 0);
    rd     = rvalid ? mem(q[0].addr) : 32'($urandom);
    i_pc_valid   = pv;
    i_pc_addr    = pa;
    i_flush      = fl;
    i_bus_gnt    = g;
    i_bus_rvalid = rvalid;
    i_bus_rdata  = rd;
    i_bus_err    = rvalid && be;
    #1;
    obs_req = o_bus_req;  obs_addr = o_bus_addr; obs_stall = o_fetch_stall;
    obs_iv  = o_inst_valid; obs_inst = o_inst;  obs_err = o_inst_err;
    chk("inst_valid", 32'(obs_iv), 32'(exp_iv));
    chk("inst", obs_inst, exp_inst);
    chk("inst_err", 32'(obs_err), 32'(exp_err));

    er = 0; es = 0; mis_acc = 0; ea = '0;
    if (m_hold) begin
      er = 1; ea = m_hold_addr; es = !g || m_hold_kill;
    end else if (pv && !fl) begin
      if (pa[1:0] != 2'b00) begin
        es = q.size() != 0; mis_acc = q.size() == 0;
      end else if (q.size() < MAX) begin
        er = 1; ea = {pa[31:2], 2'b00}; es = !g;
      end else begin
        es = 1;
      end
    end
    chk("bus_req", 32'(obs_req), 32'(er));
    if (er) chk("bus_addr", obs_addr, ea);
    if (!fl) chk("fetch_stall", 32'(obs_stall), 32'(es));
    last_es = es;

    exp_iv = 1'b0;
    if (rvalid) begin
      e = q.pop_front();
      if (!e.killed && !fl) begin
        exp_iv = 1'b1; exp_inst = rd; exp_err = be;
      end
    end else if (mis_acc) begin
      exp_iv = 1'b1; exp_inst = NOP; exp_err = 1'b1;
    end
    if (er && g) begin
      e.addr = ea;
      e.killed = fl || (m_hold && m_hold_kill);
      q.push_back(e);
    end
    if (fl) foreach (q[i]) q[i].killed = 1;
    if (m_hold) begin
      if (g) m_hold = 0;
      else m_hold_kill = m_hold_kill || fl;
    end else if (er && !g) begin
      m_hold = 1; m_hold_addr = ea; m_hold_kill = 0;
    end
  endtask

  task automatic drain();
    repeat (6) cycle(0, '0, 0, 0, 1, 0);
  endtask

  initial begin
    bit          pv, fl, keep;
    logic [31:0] pa;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_bus_req", 32'(o_bus_req), 32'h0);
    chk("rst_inst_valid", 32'(o_inst_valid), 32'h0);
    chk("rst_inst", o_inst, NOP);
    chk("rst_stall", 32'(o_fetch_stall), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait bus, back-to-back fetches.
    cycle(1, 32'h0, 0, 1, 1, 0);
    chk("zw_addr0", obs_addr, 32'h0);
    cycle(1, 32'h4, 0, 1, 1, 0);
    chk("zw_addr4", obs_addr, 32'h4);
    cycle(1, 32'h8, 0, 1, 1, 0);
    chk("zw_addr8", obs_addr, 32'h8);
    chk("zw_inst0", obs_inst, 32'hDEADBEEF);
    chk("zw_stall", 32'(obs_stall), 32'h0);
    cycle(0, '0, 0, 0, 1, 0);
    chk("zw_inst4", obs_inst, 32'hDEADBEEB);
    cycle(0, '0, 0, 0, 1, 0);
    chk("zw_inst8", obs_inst, 32'hDEADBEE7);
    drain();

    // Grant withheld three cycles.
    repeat (3) begin
      cycle(1, 32'h10, 0, 0, 0, 0);
      chk("hold_addr", obs_addr, 32'h10);
      chk("hold_stall", 32'(obs_stall), 32'h1);
    end
    cycle(1, 32'h10, 0, 1, 0, 0);
    chk("hold_gnt_stall", 32'(obs_stall), 32'h0);
    drain();

    // Outstanding limit with slow responses.
    cycle(1, 32'h40, 0, 1, 0, 0);
    cycle(1, 32'h44, 0, 1, 0, 0);
    repeat (3) begin
      cycle(1, 32'h48, 0, 1, 0, 0);
      chk("full_req", 32'(obs_req), 32'h0);
      chk("full_stall", 32'(obs_stall), 32'h1);
    end
    cycle(1, 32'h48, 0, 1, 1, 0);
    chk("full_rv_stall", 32'(obs_stall), 32'h1);
    cycle(1, 32'h48, 0, 1, 0, 0);
    chk("full_inst40", obs_inst, 32'hDEADBEAF);
    chk("full_addr48", obs_addr, 32'h48);
    cycle(0, '0, 0, 0, 1, 0);
    cycle(0, '0, 0, 0, 1, 0);
    chk("full_inst44", obs_inst, 32'hDEADBEAB);
    cycle(0, '0, 0, 0, 0, 0);
    chk("full_inst48", obs_inst, 32'hDEADBEA7);
    drain();

    // Flush with two reads in flight.
    cycle(1, 32'h80, 0, 1, 0, 0);
    cycle(1, 32'h84, 0, 1, 0, 0);
    cycle(0, '0, 1, 0, 0, 0);
    cycle(0, '0, 0, 0, 1, 0);
    cycle(0, '0, 0, 0, 1, 0);
    chk("flush_drop0", 32'(obs_iv), 32'h0);
    cycle(1, 32'h100, 0, 1, 0, 0);
    chk("flush_drop1", 32'(obs_iv), 32'h0);
    cycle(0, '0, 0, 0, 1, 0);
    cycle(0, '0, 0, 0, 0, 0);
    chk("flush_new_valid", 32'(obs_iv), 32'h1);
    chk("flush_new_inst", obs_inst, 32'hDEADBFEF);
    drain();

    // Bus error response.
    cycle(1, 32'h20, 0, 1, 0, 0);
    cycle(0, '0, 0, 0, 1, 1);
    cycle(0, '0, 0, 0, 0, 0);
    chk("berr_valid", 32'(obs_iv), 32'h1);
    chk("berr_err", 32'(obs_err), 32'h1);
    drain();

    // Misaligned fetch.
    cycle(1, 32'h22, 0, 1, 0, 0);
    chk("mis_req", 32'(obs_req), 32'h0);
    cycle(0, '0, 0, 0, 0, 0);
    chk("mis_valid", 32'(obs_iv), 32'h1);
    chk("mis_err", 32'(obs_err), 32'h1);
    chk("mis_inst", obs_inst, NOP);
    drain();

    // Randomized traffic.
    keep = 0; pv = 0; pa = '0;
    for (int n = 0; n < 3000; n++) begin
      fl = $urandom_range(99) < 5;
      if (!keep) begin
        pv = $urandom_range(99) < 70;
        pa = $urandom;
        pa[1:0] = ($urandom_range(99) < 6) ? 2'($urandom_range(3, 1)) : 2'b00;
      end
      cycle(pv, pa, fl, $urandom_range(99) < 60, $urandom_range(99) < 50,
            $urandom_range(99) < 10);
      keep = pv && last_es && !fl;
    end
    drain();

    // Reset in the middle of a transfer.
    cycle(1, 32'h30, 0, 1, 0, 0);
    cycle(1, 32'h34, 0, 1, 1, 0);
    @(negedge clk);
    i_pc_valid = 1; i_pc_addr = 32'h38; i_flush = 0; i_bus_gnt = 0; i_bus_rvalid = 0;
    #1;
    chk("pre_rst_valid", 32'(o_inst_valid), 32'h1);
    chk("pre_rst_inst", o_inst, 32'hDEADBEDF);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_bus_req", 32'(o_bus_req), 32'h0);
    chk("arst_stall", 32'(o_fetch_stall), 32'h0);
    chk("arst_valid", 32'(o_inst_valid), 32'h0);
    chk("arst_inst", o_inst, NOP);
    chk("arst_err", 32'(o_inst_err), 32'h0);
    model_reset();
    @(negedge clk);
    i_pc_valid = 0;
    rst = 1'b0;
    cycle(1, 32'h200, 0, 1, 1, 0);
    cycle(0, '0, 0, 0, 1, 0);
    cycle(0, '0, 0, 0, 0, 0);
    chk("post_rst_inst", obs_inst, 32'hDEADBCEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
